// File: rtl/div_unit_if.sv
// div_unit_if: pipeline <-> divider handshake for DIV/DIVU in the execute stage.
//   start        pipeline -> divider  divide instruction present in E (held while div_stall)
//   signed_div   pipeline -> divider  1 = DIV, 0 = DIVU, sampled with start
//   a, b         pipeline -> divider  dividend / divisor, sampled with start
//   annul        pipeline -> divider  cancel the in-flight divide (E flush)
//   div_stall    divider -> pipeline  freeze F/D/E (hazard divstallE)
//   result_ready divider -> pipeline  one-cycle pulse, hi/lo valid
//   hi, lo       divider -> pipeline  remainder / quotient
interface div_unit_if #(parameter int WIDTH = 32);
  logic start, signed_div, annul, div_stall, result_ready;
  logic [WIDTH-1:0] a, b, hi, lo;
  modport master(output start, signed_div, a, b, annul, input div_stall, result_ready, hi, lo);
  modport slave(input start, signed_div, a, b, annul, output div_stall, result_ready, hi, lo);
endinterface

// File: rtl/div_unit.sv
// div_unit: multi-cycle radix-2 restoring divider (DIV/DIVU), fixed WIDTH-cycle iteration.
//   clk     pipeline clock, rising edge
//   resetn  asynchronous active-low reset
//   bus     div_unit_if slave: start/signed_div/a/b/annul in, div_stall/result_ready/hi/lo out
module div_unit #(parameter int WIDTH = 32) (
  input logic clk,
  input logic resetn,
  div_unit_if.slave bus
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic [1:0] {IDLE, BUSY, DONE} stateT;
  stateT state;
  logic [CW-1:0] count;
  logic [WIDTH-1:0] rem, quo, divisor, aRaw;
  logic negQuo, negRem, divZero;
  logic [WIDTH:0] trial;
  logic [WIDTH-1:0] nextRem, nextQuo, aMag, bMag;
  // {rem,quo} shifted left by one; trial subtraction is one bit wider so its MSB is the borrow
  assign trial = {rem, quo[WIDTH-1]} - {1'b0, divisor};
  assign nextRem = trial[WIDTH] ? {rem[WIDTH-2:0], quo[WIDTH-1]} : trial[WIDTH-1:0];
  assign nextQuo = {quo[WIDTH-2:0], ~trial[WIDTH]};
  assign aMag = (bus.signed_div & bus.a[WIDTH-1]) ? -bus.a : bus.a;
  assign bMag = (bus.signed_div & bus.b[WIDTH-1]) ? -bus.b : bus.b;
  // gated by resetn so the stall is released while reset is held, even with start high
  assign bus.div_stall = resetn & ~bus.annul & ((state == IDLE & bus.start) | (state == BUSY));
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= IDLE;
      count <= '0;
      rem <= '0;
      quo <= '0;
      divisor <= '0;
      aRaw <= '0;
      negQuo <= 1'b0;
      negRem <= 1'b0;
      divZero <= 1'b0;
      bus.hi <= '0;
      bus.lo <= '0;
      bus.result_ready <= 1'b0;
    end else begin
      bus.result_ready <= 1'b0;
      case (state)
        IDLE: if (bus.start && !bus.annul) begin
          rem <= '0;
          quo <= aMag;
          divisor <= bMag;
          aRaw <= bus.a;
          negQuo <= bus.signed_div & (bus.a[WIDTH-1] ^ bus.b[WIDTH-1]);
          negRem <= bus.signed_div & bus.a[WIDTH-1];
          divZero <= (bus.b == '0);
          count <= '0;
          state <= BUSY;
        end
        BUSY: if (bus.annul) state <= IDLE;
        else begin
          rem <= nextRem;
          quo <= nextQuo;
          count <= count + 1'b1;
          if (count == CW'(WIDTH - 1)) begin
            state <= DONE;
            bus.result_ready <= 1'b1;
            // divide by zero bypasses the sign fix-up: lo all ones, hi the raw dividend
            bus.lo <= divZero ? '1 : (negQuo ? -nextQuo : nextQuo);
            bus.hi <= divZero ? aRaw : (negRem ? -nextRem : nextRem);
          end
        end
        // start still belongs to the completing instruction here, so it never restarts
        default: state <= IDLE;
      endcase
    end
  end
endmodule
